uart_alu_frame_ctrl: RTL
========================

Name: uart_alu_frame_ctrl

Overview:
Parametrised command/response controller placed between uart_core's FIFO interface and alu_logic. It replaces the single-byte operand interface with framed, multi-byte transfers: operands are OP_BYTES bytes wide, every frame is checksum-protected, and stalled frames are dropped by an inter-byte timeout. Every response carries a status byte. The ALU stays external and combinational; this block registers its operands, captures its result and serialises the response.

Parameters:
DBIT, 8, UART byte width
OP_BYTES, 2, bytes per operand/result; W = DBIT*OP_BYTES
OPC_W, 6, ALU opcode width
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 100000, max idle clk cycles between bytes of one frame (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
i_rx_data  in  DBIT  RX FIFO head byte (first-word-fall-through)
i_rx_empty  in  1  RX FIFO empty
o_rd_uart  out  1  one-cycle pop of RX FIFO
o_tx_data  out  DBIT  byte to TX FIFO
i_tx_full  in  1  TX FIFO full
o_wr_uart  out  1  one-cycle push to TX FIFO
o_op_a  out  W  ALU operand A (registered)
o_op_b  out  W  ALU operand B (registered)
o_op_code  out  OPC_W  ALU opcode (registered)
i_result  in  W  ALU result
o_busy  out  1  high in any state other than IDLE
o_frame_done  out  1  one-cycle pulse after the status byte is pushed

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs, operand/result registers, byte counter, checksum and timeout counter = 0. Applies in any state. The partial frame is lost. RX/TX FIFO contents are not touched.
- RX handshake: o_rd_uart asserts only while i_rx_empty==0. i_rx_data is sampled in the same cycle. At most one pop per cycle. Pops are never issued outside RX states.
- TX handshake: o_wr_uart asserts only while i_tx_full==0, with o_tx_data valid in the same cycle. While the TX FIFO is full the controller holds: no push, byte index frozen.
- Frame in: SYNC_BYTE, OPC, A[0..OP_BYTES-1] (LSB first), B[0..OP_BYTES-1] (LSB first), CHK.
- CHK = XOR of OPC, all A bytes and all B bytes. SYNC_BYTE is excluded.
- OPC bits [OPC_W-1:0] are used; upper bits are ignored but still included in CHK.
- States:
  - IDLE: pop bytes. SYNC_BYTE -> RX_OPC. Any other byte is discarded and the state stays IDLE.
  - RX_OPC, RX_A, RX_B, RX_CHK: one byte per pop. A byte counter indexes operand bytes and wraps 0..OP_BYTES-1 between RX_A and RX_B. The running XOR checksum updates on every pop.
  - In RX_CHK: match -> load o_op_a, o_op_b and o_op_code from shadow registers, go to EXEC. Mismatch -> status=8'h01, result register=0, go to TX_RES. Operand outputs keep their previous values.
  - EXEC (1 cycle): capture i_result into the result register, status=8'h00, go to TX_RES. Latency from CHK pop to the first possible result push = 2 cycles.
  - TX_RES: push result bytes LSB first, OP_BYTES pushes.
  - TX_STAT: push the status byte, pulse o_frame_done, go to IDLE.
- Timeout: the counter clears on every pop and counts while in RX_OPC..RX_CHK with i_rx_empty==1. On reaching TIMEOUT the frame is aborted: result=0, status=8'h02, go to TX_RES.
- A SYNC_BYTE value received mid-frame is treated as data, with no resync.
- Operand outputs hold their values until the next valid frame, so ALU inputs stay stable between frames.

Test Plan:
- OP_BYTES=2, ALU ADD opcode 0x20, RX A5 20 34 12 05 00 03 -> o_op_a=0x1234, o_op_b=0x0005; TX 39 12 00; one o_frame_done pulse.
- Same frame with CHK=0x04 -> TX 00 00 01; o_op_a/o_op_b unchanged from the previous frame.
- RX 11 FF A5 followed by a valid frame body -> 0x11 and 0xFF are popped and dropped; response identical to the first scenario.
- TIMEOUT=50, RX A5 20 34, then silence -> exactly 50 idle cycles later TX 00 00 02; o_busy drops after the status byte is pushed.
- i_tx_full held high for 20 cycles during TX_RES -> no o_wr_uart while full; resumes with the correct byte; no duplicated or skipped bytes.
- reset=0 for one cycle after RX A5 20 34 -> all outputs 0 and state IDLE; a following full valid frame completes normally.

Source files
------------

// File: rtl/uart_alu_frame_ctrl.sv
// Framed command/response bridge between a UART FIFO pair and an external
// combinational ALU: checksummed multi-byte operands in, result + status out.
module uart_alu_frame_ctrl #(
  parameter int unsigned     DBIT      = 8,
  parameter int unsigned     OP_BYTES  = 2,
  parameter int unsigned     OPC_W     = 6,
  parameter logic [DBIT-1:0] SYNC_BYTE = DBIT'(8'hA5),
  parameter int unsigned     TIMEOUT   = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DBIT-1:0]            i_rx_data,
  input  logic                       i_rx_empty,
  output logic                       o_rd_uart,
  output logic [DBIT-1:0]            o_tx_data,
  input  logic                       i_tx_full,
  output logic                       o_wr_uart,
  output logic [DBIT*OP_BYTES-1:0]   o_op_a,
  output logic [DBIT*OP_BYTES-1:0]   o_op_b,
  output logic [OPC_W-1:0]           o_op_code,
  input  logic [DBIT*OP_BYTES-1:0]   i_result,
  output logic                       o_busy,
  output logic                       o_frame_done
);

  localparam int unsigned W      = DBIT * OP_BYTES;
  localparam int unsigned CNT_W  = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(OP_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [DBIT-1:0]  ST_OK      = DBIT'(8'h00);
  localparam logic [DBIT-1:0]  ST_CHK_ERR = DBIT'(8'h01);
  localparam logic [DBIT-1:0]  ST_TMO     = DBIT'(8'h02);

  typedef enum logic [2:0] {
    IDLE, RX_OPC, RX_A, RX_B, RX_CHK, EXEC, TX_RES, TX_STAT
  } state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      a_sh, b_sh, res_q;
  logic [OPC_W-1:0]  opc_sh;
  logic [DBIT-1:0]   chk_q, status_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              rx_st, tmo_hit, chk_ok, last_byte;

  assign rx_st     = (state == RX_OPC) || (state == RX_A) ||
                     (state == RX_B)   || (state == RX_CHK);
  assign tmo_hit   = rx_st && i_rx_empty && (tmo_cnt == TMO_LAST);
  assign chk_ok    = (chk_q == i_rx_data);
  assign last_byte = (byte_cnt == LAST_BYTE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a stalled frame jumps straight to the response
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (o_rd_uart && i_rx_data == SYNC_BYTE) state_nxt = RX_OPC;
      RX_OPC:  if (o_rd_uart) state_nxt = RX_A;
               else if (tmo_hit) state_nxt = TX_RES;
      RX_A:    if (o_rd_uart && last_byte) state_nxt = RX_B;
               else if (tmo_hit) state_nxt = TX_RES;
      RX_B:    if (o_rd_uart && last_byte) state_nxt = RX_CHK;
               else if (tmo_hit) state_nxt = TX_RES;
      RX_CHK:  if (o_rd_uart) state_nxt = chk_ok ? EXEC : TX_RES;
               else if (tmo_hit) state_nxt = TX_RES;
      EXEC:    state_nxt = TX_RES;
      TX_RES:  if (o_wr_uart && last_byte) state_nxt = TX_STAT;
      TX_STAT: if (o_wr_uart) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO handshakes follow the FIFO flags combinationally
  always_comb begin
    o_rd_uart = 1'b0;
    o_wr_uart = 1'b0;
    o_tx_data = '0;
    o_busy    = (state != IDLE);
    if (reset) begin
      case (state)
        IDLE, RX_OPC, RX_A, RX_B, RX_CHK: o_rd_uart = !i_rx_empty;
        TX_RES: begin
          o_wr_uart = !i_tx_full;
          o_tx_data = res_q[DBIT-1:0];
        end
        TX_STAT: begin
          o_wr_uart = !i_tx_full;
          o_tx_data = status_q;
        end
        default: ;
      endcase
    end
  end

  // Datapath: shadow operands, checksum, timeout, result shifter
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sh         <= '0;
      b_sh         <= '0;
      res_q        <= '0;
      opc_sh       <= '0;
      chk_q        <= '0;
      status_q     <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      o_op_a       <= '0;
      o_op_b       <= '0;
      o_op_code    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (rx_st && i_rx_empty && !tmo_hit) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                 tmo_cnt <= '0;

      case (state)
        IDLE: begin
          chk_q    <= '0;
          byte_cnt <= '0;
        end
        RX_OPC: if (o_rd_uart) begin
          opc_sh <= i_rx_data[OPC_W-1:0];
          chk_q  <= chk_q ^ i_rx_data;
        end
        RX_A: if (o_rd_uart) begin
          a_sh[DBIT*byte_cnt +: DBIT] <= i_rx_data;
          chk_q    <= chk_q ^ i_rx_data;
          byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
        end
        RX_B: if (o_rd_uart) begin
          b_sh[DBIT*byte_cnt +: DBIT] <= i_rx_data;
          chk_q    <= chk_q ^ i_rx_data;
          byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
        end
        RX_CHK: if (o_rd_uart) begin
          if (chk_ok) begin
            o_op_a    <= a_sh;
            o_op_b    <= b_sh;
            o_op_code <= opc_sh;
          end else begin
            res_q    <= '0;
            status_q <= ST_CHK_ERR;
          end
        end
        EXEC: begin
          res_q    <= i_result;
          status_q <= ST_OK;
        end
        TX_RES: if (o_wr_uart) begin
          res_q    <= res_q >> DBIT;
          byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
        end
        TX_STAT: if (o_wr_uart) o_frame_done <= 1'b1;
        default: ;
      endcase

      if (tmo_hit) begin
        res_q    <= '0;
        status_q <= ST_TMO;
        byte_cnt <= '0;
      end
    end
  end

endmodule
